// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared TinyRV1 data-memory port.
// Grants P or E each cycle, routes the one-cycle-later response back to its owner and counts conflicts.
module dmem_arbiter #(
  parameter int EXT_PRIORITY = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_req_val,
  output logic             p_req_rdy,
  input  logic             p_req_type,
  input  logic [31:0]      p_req_addr,
  input  logic [31:0]      p_req_wdata,
  output logic             p_resp_val,
  output logic [31:0]      p_resp_rdata,
  input  logic             e_req_val,
  output logic             e_req_rdy,
  input  logic             e_req_type,
  input  logic [31:0]      e_req_addr,
  input  logic [31:0]      e_req_wdata,
  output logic             e_resp_val,
  output logic [31:0]      e_resp_rdata,
  output logic             mem_req_val,
  output logic             mem_req_type,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_wdata,
  input  logic [31:0]      mem_resp_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic OWN_P = 1'b0;
  localparam logic OWN_E = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             last_grant_q, last_grant_d;
  logic             resp_pending_q, resp_pending_d;
  logic             resp_owner_q, resp_owner_d;
  logic             resp_is_rd_q, resp_is_rd_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

  logic conflict;
  logic grant_p;
  logic grant_e;

  // Grant depends only on current requests and last_grant, so it is valid in the same cycle.
  always_comb begin
    conflict = p_req_val & e_req_val;
    grant_p  = 1'b0;
    grant_e  = 1'b0;
    if (conflict) begin
      if (EXT_PRIORITY != 0) begin
        grant_e = 1'b1;
      end else if (last_grant_q == OWN_E) begin
        grant_p = 1'b1;
      end else begin
        grant_e = 1'b1;
      end
    end else begin
      grant_p = p_req_val;
      grant_e = e_req_val;
    end
  end

  always_comb begin
    mem_req_type  = 1'b0;
    mem_req_addr  = 32'h0;
    mem_req_wdata = 32'h0;
    if (grant_p) begin
      mem_req_type  = p_req_type;
      mem_req_addr  = p_req_addr;
      mem_req_wdata = p_req_wdata;
    end else if (grant_e) begin
      mem_req_type  = e_req_type;
      mem_req_addr  = e_req_addr;
      mem_req_wdata = e_req_wdata;
    end
  end

  assign mem_req_val = p_req_val | e_req_val;
  assign p_req_rdy   = grant_p;
  assign e_req_rdy   = grant_e;

  always_comb begin
    last_grant_d   = last_grant_q;
    resp_pending_d = grant_p | grant_e;
    resp_owner_d   = grant_e ? OWN_E : OWN_P;
    resp_is_rd_d   = grant_e ? ~e_req_type : ~p_req_type;
    conflict_cnt_d = conflict_cnt_q;
    if (grant_p) begin
      last_grant_d = OWN_P;
    end else if (grant_e) begin
      last_grant_d = OWN_E;
    end
    if (conflict && (conflict_cnt_q != CNT_MAX)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q   <= OWN_E;
      resp_pending_q <= 1'b0;
      resp_owner_q   <= OWN_P;
      resp_is_rd_q   <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      last_grant_q   <= last_grant_d;
      resp_pending_q <= resp_pending_d;
      resp_owner_q   <= resp_owner_d;
      resp_is_rd_q   <= resp_is_rd_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Write acknowledges carry zero data; only reads forward the memory word.
  assign p_resp_val   = resp_pending_q & (resp_owner_q == OWN_P);
  assign e_resp_val   = resp_pending_q & (resp_owner_q == OWN_E);
  assign p_resp_rdata = (p_resp_val && resp_is_rd_q) ? mem_resp_rdata : 32'h0;
  assign e_resp_rdata = (e_resp_val && resp_is_rd_q) ? mem_resp_rdata : 32'h0;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter sharing the single data-memory port of the TinyRV1 processor memory. Requester P is the processor data interface; requester E is the external memory interface (test bench loader/debug). It replaces the combinational OR-mux in front of the memory with val/rdy handshakes, round-robin or fixed-priority grant, response routing to the granted requester, and a conflict counter.

Parameters:
EXT_PRIORITY, 0, 0 = round-robin between P and E; 1 = E always wins a conflict
CNT_W, 16, width of the conflict counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
p_req_val  input  1  P request valid
p_req_rdy  output  1  P request granted this cycle
p_req_type  input  1  0 = read, 1 = write
p_req_addr  input  32  P byte address
p_req_wdata  input  32  P write data
p_resp_val  output  1  P response valid
p_resp_rdata  output  32  P read data
e_req_val  input  1  E request valid
e_req_rdy  output  1  E request granted this cycle
e_req_type  input  1  0 = read, 1 = write
e_req_addr  input  32  E byte address
e_req_wdata  input  32  E write data
e_resp_val  output  1  E response valid
e_resp_rdata  output  32  E read data
mem_req_val  output  1  request to memory
mem_req_type  output  1  forwarded type
mem_req_addr  output  32  forwarded address
mem_req_wdata  output  32  forwarded write data
mem_resp_rdata  input  32  memory read data, valid the cycle after a read request
conflict_cnt  output  CNT_W  count of cycles where both requesters were valid

Behaviour:
- A transfer occurs on a requester when its req_val and req_rdy are both high at a rising clk edge. Memory always accepts, so there is no backpressure from memory.
- Grant is combinational in the same cycle:
  - Only one req_val high: that requester is granted.
  - Both high, EXT_PRIORITY=1: E is granted.
  - Both high, EXT_PRIORITY=0: the requester not recorded in last_grant is granted.
- req_rdy is never high without the matching req_val. p_req_rdy and e_req_rdy are never both high.
- mem_req_val = p_req_val | e_req_val. mem_req_type, mem_req_addr and mem_req_wdata come from the granted requester.
- When mem_req_val is low, the mem_req data fields are driven 0, not X.
- last_grant register:
  - Updates only on cycles with a grant, to the granted requester.
  - Holds otherwise.
  - Reset value is E, so P wins the first conflict after reset.
- Response pipeline: one stage of registers, resp_owner (P/E), resp_is_rd and resp_pending, captured at each grant.
- The cycle after a grant, the owner's resp_val is high for exactly one cycle:
  - Read: the owner's resp_rdata = mem_resp_rdata.
  - Write: resp_rdata = 0; resp_val serves as the write acknowledge.
- The non-owner's resp_val is 0 and its resp_rdata is 0.
- Back-to-back grants (one per cycle, either requester) are fully pipelined. Throughput is 1 request/cycle, latency is 1 cycle.
- A read issued the cycle after a write to the same address returns the new data. This relies on memory write-first ordering; the arbiter adds no reordering.
- conflict_cnt:
  - Increments on every cycle with p_req_val & e_req_val.
  - Saturates at all-ones; does not wrap.
- A requester that drops req_val before being granted has no side effects.
- Reset values: last_grant = E, resp_pending = 0, p_resp_val = e_resp_val = 0, both resp_rdata = 0, conflict_cnt = 0.
- Grant outputs are combinational from inputs and last_grant, so they are valid in the first cycle after reset release.
- Reset asserted mid-operation: any in-flight response is dropped, with no resp_val after reset deasserts. Any memory write already granted at a prior edge is not undone.
- During reset the combinational grant and mem_req outputs still follow inputs. Integrators hold the requesters idle during reset.

Test Plan:
- Reset then idle: rst pulse -> all resp_val 0, conflict_cnt 0, mem_req_val 0, mem_req_addr 0.
- P only: write 0x0000_00AB to 0x100, then read 0x100 -> p_req_rdy high both cycles; p_resp_val 1 cycle after each; read returns 0xAB; e_resp_val stays 0.
- Conflict, round-robin (EXT_PRIORITY=0): P and E both hold reads of 0x200 and 0x204 for 4 cycles -> grants P,E,P,E; each resp_val follows its grant by 1 cycle with the correct word; conflict_cnt = 4.
- Conflict, EXT_PRIORITY=1: both valid for 3 cycles -> e_req_rdy high all 3 cycles, p_req_rdy 0; E drops val in cycle 4 -> P granted in cycle 4.
- Pipelined mixed traffic: E writes 0xDEAD_BEEF to 0x300, next cycle P reads 0x300 -> P read returns 0xDEADBEEF; E gets a write ack with rdata 0; no cycle with both resp_val high.
- Reset mid-read plus saturation: assert rst the cycle after a P read grant -> p_resp_val never rises. Separately, with CNT_W=4, hold both valid 20 cycles -> conflict_cnt = 15.
